// File: rtl/setting_apply.sv
// setting_apply: qualifies a setting word crossed from an upstream FIFO and
// commits it to dataOut only after it has been stable for SETTLE_CYCLES and a
// vsync rising edge (or the optional timeout) has been seen.
module setting_apply #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      SETTLE_CYCLES  = 4,
  parameter int unsigned      TIMEOUT_CYCLES = 1048576,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             vsync,
  output logic [WIDTH-1:0] dataOut,
  output logic             applied,
  output logic             pending
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_VS
  } state_t;

  // Settle counter value on which the word is declared stable; the transition
  // happens on the edge that samples this value, giving SETTLE_CYCLES edges
  // from the change edge to WAIT_VS.
  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [WIDTH-1:0] candidate;
  logic [7:0]       settle_cnt;
  logic [23:0]      timeout_cnt;
  logic             vsync_prev;

  logic             vsync_rise;
  logic             timeout_hit;

  // Frame edge and timeout detection from the current registered state.
  always_comb begin
    vsync_rise  = vsync & ~vsync_prev;
    timeout_hit = TIMEOUT_EN && (timeout_cnt == TIMEOUT_LAST);
  end

  // Qualification FSM with registered outputs; dataOut is loaded whole from
  // candidate so it never shows a partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dataOut     <= RESET_VALUE;
      applied     <= 1'b0;
      pending     <= 1'b0;
      candidate   <= RESET_VALUE;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      vsync_prev  <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      applied    <= 1'b0;
      case (state)
        IDLE: begin
          if (dataIn != dataOut) begin
            candidate  <= dataIn;
            settle_cnt <= '0;
            pending    <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (dataIn == dataOut) begin
            pending <= 1'b0;
            state   <= IDLE;
          end else if (dataIn != candidate) begin
            candidate  <= dataIn;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            timeout_cnt <= '0;
            state       <= WAIT_VS;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        WAIT_VS: begin
          // A data change outranks a frame edge or timeout in the same cycle.
          if (dataIn == dataOut) begin
            pending <= 1'b0;
            state   <= IDLE;
          end else if (dataIn != candidate) begin
            candidate  <= dataIn;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (vsync_rise || timeout_hit) begin
            dataOut <= candidate;
            applied <= 1'b1;
            pending <= 1'b0;
            state   <= IDLE;
          end else if (timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 24'd1;
          end
        end
        default: begin
          pending <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setting_apply.sv
// tb_setting_apply: directed vector bench for setting_apply with
// SETTLE_CYCLES=4 and TIMEOUT_CYCLES=16.
module tb_setting_apply;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataIn = 8'h77;
  logic       vsync = 1'b0;
  logic [7:0] dataOut;
  logic       applied;
  logic       pending;

  int n_cmp = 0;
  int n_bad = 0;

  setting_apply #(
    .WIDTH         (8),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(16),
    .RESET_VALUE   (8'h00)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .dataIn (dataIn),
    .vsync  (vsync),
    .dataOut(dataOut),
    .applied(applied),
    .pending(pending)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [7:0] din;
    logic       vs;
    logic [7:0] dout;
    logic       ap;
    logic       pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string tag, logic [7:0] din, logic vs,
                              logic [7:0] dout, logic ap, logic pend);
    vec_t v;
    v.tag  = tag;
    v.din  = din;
    v.vs   = vs;
    v.dout = dout;
    v.ap   = ap;
    v.pend = pend;
    vecs.push_back(v);
  endfunction

  task automatic check(string tag, logic [7:0] dout, logic ap, logic pend);
    n_cmp++;
    if (dataOut !== dout || applied !== ap || pending !== pend) begin
      n_bad++;
      $display("FAIL %s: got dataOut=%h applied=%b pending=%b, want dataOut=%h applied=%b pending=%b",
               tag, dataOut, applied, pending, dout, ap, pend);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(logic [7:0] din, logic vs);
    @(negedge clock);
    dataIn = din;
    vsync  = vs;
    @(posedge clock);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Glitch: two cycles of 0x5A then back to 0x00, plus a rise while idle.
    add("glitch_chg",   8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("glitch_hold",  8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("glitch_rev",   8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add("glitch_idle_rise", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    add("glitch_idle",  8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // Normal commit: change, rise during settle ignored, rise 10 cycles later.
    add("norm_chg",     8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("norm_s1",      8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("norm_s2_rise", 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1);
    add("norm_s3",      8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("norm_to_wait", 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add("norm_wait", 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    add("norm_commit",  8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0);
    add("norm_post_hi", 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0);
    add("norm_post_lo", 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0);
    // Timeout: 0x81 with vsync low commits 16 edges after entering WAIT_VS.
    add("to_chg",       8'h81, 1'b0, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add("to_settle", 8'h81, 1'b0, 8'h5A, 1'b0, 1'b1);
    add("to_enter_wait", 8'h81, 1'b0, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) add("to_wait", 8'h81, 1'b0, 8'h5A, 1'b0, 1'b1);
    add("to_commit",    8'h81, 1'b0, 8'h81, 1'b1, 1'b0);
    add("to_post",      8'h81, 1'b0, 8'h81, 1'b0, 1'b0);
    add("to_post2",     8'h81, 1'b0, 8'h81, 1'b0, 1'b0);

    // Asynchronous reset with dataIn=0x77, before any clock edge.
    #1 reset = 1'b0;
    #1 check("reset_async", 8'h00, 1'b0, 1'b0);
    dataIn = 8'h00;
    repeat (2) @(posedge clock);
    #1 check("reset_held", 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].din, vecs[i].vs);
      check(vecs[i].tag, vecs[i].dout, vecs[i].ap, vecs[i].pend);
    end

    // Re-settle: change to 0x33 coincides with a rise while 0x5A waits.
    step(8'h5A, 1'b0);
    check("rs_chg", 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'h5A, 1'b0);
      check("rs_settle", 8'h81, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      step(8'h5A, 1'b0);
      check("rs_wait", 8'h81, 1'b0, 1'b1);
    end
    step(8'h33, 1'b1);
    check("rs_chg_on_rise", 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'h33, 1'b1);
      check("rs_resettle", 8'h81, 1'b0, 1'b1);
    end
    step(8'h33, 1'b0);
    check("rs_wait2", 8'h81, 1'b0, 1'b1);
    step(8'h33, 1'b1);
    check("rs_commit", 8'h33, 1'b1, 1'b0);
    step(8'h33, 1'b0);
    check("rs_post", 8'h33, 1'b0, 1'b0);

    // Reset mid-WAIT_VS with candidate 0x42 discards the candidate.
    step(8'h42, 1'b0);
    check("rm_chg", 8'h33, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(8'h42, 1'b0);
      check("rm_settle_wait", 8'h33, 1'b0, 1'b1);
    end
    #2 reset = 1'b0;
    #1 check("rm_async", 8'h00, 1'b0, 1'b0);
    dataIn = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(8'h00, 1'b0);
    check("rm_post_lo", 8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1);
    check("rm_post_rise", 8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0);
    check("rm_post_end", 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/setting_apply.md
SETTING_APPLY -- requirements
Module: setting_apply

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8: width of the setting word.
REQ-002 The block SHALL have the parameter SETTLE_CYCLES, default 4: number of consecutive stable cycles required before a new word is accepted; legal range 1..255.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 1048576: number of cycles in WAIT_VS after which the word commits without a frame edge; 0 disables the timeout; legal range 0..2^24-1.
REQ-004 The block SHALL have the parameter RESET_VALUE, default 0: value of dataOut while reset is asserted and after reset.
REQ-005 The block SHALL have the port clock, input, 1 bit: the single clock, which is the read-side (clkOut) domain of the upstream FIFO crossing; all logic is rising-edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port dataIn, input, WIDTH bits: the crossed setting word from the upstream FIFO q output, synchronous to clock.
REQ-008 The block SHALL have the port vsync, input, 1 bit: frame sync level, synchronous to clock; only its rising edge is significant.
REQ-009 The block SHALL have the port dataOut, output reg, WIDTH bits: the committed setting word.
REQ-010 The block SHALL have the port applied, output reg, 1 bit: single-cycle pulse in the cycle dataOut takes a new value.
REQ-011 The block SHALL have the port pending, output reg, 1 bit: high while a candidate word differing from dataOut is being qualified or is awaiting commit.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE and WAIT_VS.
REQ-013 Internal registers SHALL be: candidate[WIDTH], settle counter (8 bits), timeout counter (24 bits) and vsync_prev (1 bit).
REQ-014 A rising edge SHALL be defined as vsync=1 and vsync_prev=1'b0; vsync_prev is updated every clock.
REQ-015 In IDLE, if dataIn != dataOut, the FSM SHALL set candidate<=dataIn, clear the settle counter, move to SETTLE and set pending<=1.
REQ-016 In SETTLE, if dataIn == dataOut, the FSM SHALL move to IDLE with pending<=0; this is a revert and no commit occurs.
REQ-017 In SETTLE, else if dataIn != candidate, the FSM SHALL set candidate<=dataIn, clear the settle counter and stay in SETTLE.
REQ-018 In SETTLE, otherwise the settle counter SHALL increment; when it reaches SETTLE_CYCLES-1 on that edge, the FSM SHALL move to WAIT_VS and clear the timeout counter.
REQ-019 In WAIT_VS, a dataIn change SHALL follow the same rules as SETTLE: a revert goes to IDLE, a new value goes to SETTLE with the counter cleared. A change has priority over a vsync edge or timeout in the same cycle.
REQ-020 In WAIT_VS, on a vsync rising edge, or when the timeout counter equals TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0, the FSM SHALL set dataOut<=candidate, applied<=1 and pending<=0, and move to IDLE.
REQ-021 In WAIT_VS, otherwise the timeout counter SHALL increment, saturating and never wrapping.
REQ-022 applied SHALL be 0 in every cycle other than the commit cycle, so a back-to-back commit is at least SETTLE_CYCLES+2 cycles apart.
REQ-023 Latency: with dataIn stable after a change sampled at edge E0, the FSM SHALL be in WAIT_VS after edge E0+SETTLE_CYCLES, and dataOut SHALL update on the edge that samples the first vsync rise thereafter.
REQ-024 A vsync rise that occurs during IDLE or SETTLE SHALL be ignored; the commit waits for the next rise.
REQ-025 dataOut SHALL change only via the commit rule or reset, and SHALL never hold a partially-updated word.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force: state=IDLE, dataOut=RESET_VALUE, applied=0, pending=0, candidate=RESET_VALUE, both counters=0, vsync_prev=0.
REQ-027 Reset asserted mid-SETTLE or mid-WAIT_VS SHALL discard the candidate, so no commit occurs after release.
REQ-028 After release, a vsync already high SHALL count as a rising edge on the first sampling edge.

Verification (WIDTH=8, SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, RESET_VALUE=0)
REQ-029 The bench SHALL cover reset: assert reset with dataIn=0x77 -> dataOut=0x00, applied=0, pending=0 immediately, with no clock needed.
REQ-030 The bench SHALL cover a normal commit: dataIn 0x00->0x5A held, vsync rise 10 cycles later -> pending=1 from the change edge, and dataOut=0x5A with applied=1 for exactly one cycle on the rise-sampling edge, after which pending=0.
REQ-031 The bench SHALL cover a glitch: dataIn=0x5A for 2 cycles then 0x00 -> no applied pulse, dataOut stays 0x00, and pending returns to 0.
REQ-032 The bench SHALL cover a re-settle: in WAIT_VS with candidate 0x5A, dataIn->0x33 in the same cycle as a vsync rise -> no commit that cycle; a later rise commits 0x33, and 0x5A never appears on dataOut.
REQ-033 The bench SHALL cover timeout: dataIn->0x81 with vsync held low -> commit of 0x81 exactly 16 cycles after entering WAIT_VS, with a single applied pulse.
REQ-034 The bench SHALL cover reset mid-operation: reset asserted in WAIT_VS with candidate 0x42 -> pending=0 asynchronously; after release with dataIn=0x00 and a vsync rise -> no commit and dataOut=0x00.
